cordic_chan_sched: RTL
======================

Name: cordic_chan_sched

Overview:
- Round-robin scheduler that shares one iterative CORDIC rotation core among NCH phase-accumulator channels (tone generators).
- Each channel posts a phase angle. The block arbitrates, loads the core with angle, x_start and y_start, waits for core done, then returns cos/sin tagged with the channel index.
- Sits between the per-channel angle generators and the single CORDIC datapath.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- W, 16, angle and amplitude width.
- XINIT, 1215, x_start loaded on every issue (2000*0.6073, gain-compensated).
- TIMEOUT_CYC, 64, wait-state abort limit (used only with CORDIC_TIMEOUT_EN).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ch_req  in  NCH  per-channel request, level, held until granted.
- ch_angle  in  NCH*W  channel i angle in bits [i*W +: W].
- ch_grant  out  NCH  one-hot, 1-cycle pulse; request consumed.
- cordic_start  out  1  1-cycle start pulse to core.
- cordic_angle  out  W  latched angle of granted channel.
- cordic_x  out  W  x_start to core.
- cordic_y  out  W  y_start to core, always 0.
- cordic_done  in  1  core result-ready pulse.
- cordic_cos  in  W  core x result.
- cordic_sin  in  W  core y result.
- res_valid  out  1  1-cycle result strobe.
- res_ch  out  clog2(NCH)  channel index of the result.
- res_cos  out  W  registered cos result.
- res_sin  out  W  registered sin result.
- res_err  out  1  result aborted by timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE.
  - All outputs are 0, including cordic_x.
  - Last-grant pointer is NCH-1, so ch0 has top priority after reset.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - If any ch_req is high, select the first requesting channel scanning from (last+1) mod NCH upward with wrap-around.
  - Register the index, latch its ch_angle into cordic_angle, and move to ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - cordic_start=1.
  - ch_grant[idx]=1.
  - cordic_x=XINIT, cordic_y=0.
  - last <= idx.
  - Move to WAIT.
  - cordic_done seen in this cycle is ignored.
- WAIT:
  - On cordic_done=1, capture cordic_cos/cordic_sin into res_cos/res_sin and move to DELIVER.
  - Otherwise hold.
  - cordic_angle and cordic_x stay stable throughout WAIT.
- DELIVER (1 cycle):
  - res_valid=1, res_ch=idx, res_err=0.
  - Move to IDLE.
  - res_cos/res_sin hold until the next capture.
- Latency:
  - A request seen in IDLE at cycle n gives cordic_start at n+1.
  - A done at cycle d gives res_valid at d+1.
  - The next arbitration happens at d+2.
  - Minimum service period is 4 cycles when the core finishes in 1.
- Requests:
  - Deasserting ch_req before its grant withdraws it without side effect.
  - Requests arriving in ISSUE, WAIT or DELIVER wait for the next IDLE.
  - A channel that re-requests immediately after being granted gets lowest priority next round, so there is no starvation.
- Simultaneous requests: all NCH requesting gives strict rotation ch(last+1), ch(last+2), and so on.
- Reset mid-operation: immediate return to IDLE; any in-flight result is dropped and no res_valid is produced.
- Width: the angle is passed through unmodified. Angle wrap-around is the generator's concern; the scheduler does no arithmetic on data.

Optional Feature:
- Macro: CORDIC_TIMEOUT_EN.
- When defined:
  - A clog2(TIMEOUT_CYC+1)-bit counter clears in ISSUE and increments in WAIT.
  - If it reaches TIMEOUT_CYC without cordic_done, go to DELIVER with res_err=1 and res_cos=res_sin=0.
  - A done arriving on the same cycle as the limit wins; the result is normal with res_err=0.
- When not defined:
  - No counter is built.
  - WAIT holds indefinitely.
  - res_err is tied to 0.

Decomposition:
- Package cordic_sched_pkg:
  - State enum (IDLE, ISSUE, WAIT, DELIVER).
  - Constants XINIT_DEF=1215 and TIMEOUT_DEF=64.
  - Function for the channel-index width.
- One sub-module: rr_arbiter_pick, a combinational/registered round-robin picker.
  - Inputs: req vector, last pointer.
  - Outputs: index and any-request flag.

Test Plan:
- Reset release, ch_req=0001, angle0=0x07F, core done after 16 cycles:
  - cordic_start one cycle later, cordic_angle=0x07F, cordic_x=1215, cordic_y=0.
  - res_valid 1 cycle after done, res_ch=0, values matching the core outputs.
- All four requests held high continuously: grant order 0,1,2,3,0 with no repeats and exactly one ch_grant pulse per service.
- ch_req=0100 raised during WAIT of ch0: not granted until DELIVER completes; then grant ch2 at IDLE.
- cordic_done pulsed during ISSUE, then real done 5 cycles later: only the later done is captured; exactly one res_valid.
- resetn driven low during WAIT: all outputs go to 0 asynchronously; no res_valid after release; the next grant goes to ch0.
- With CORDIC_TIMEOUT_EN, TIMEOUT_CYC=64, done never asserted: res_valid with res_err=1 and zero results 64 WAIT cycles after ISSUE; then normal arbitration resumes.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC channel scheduler.
// Optional wait-state timeout is enabled with CORDIC_TIMEOUT_EN.
package cordic_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam int unsigned XINIT_DEF   = 1215;
    localparam int unsigned TIMEOUT_DEF = 64;

    // Channel-index width, never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin picker: first requester after the last grant, with wrap.
module rr_arbiter_pick
    import cordic_sched_pkg::*;
#(
    parameter  int unsigned NCH = 4,
    localparam int unsigned IW  = chan_w(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [IW-1:0]  i_last,
    output logic [IW-1:0]  o_idx_c,
    output logic           o_any_c
);

    logic [31:0] w_pos;
    logic        w_found;

    always_comb begin
        o_idx_c = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            w_pos = (32'(i_last) + k) % NCH;
            if (!w_found && i_req[IW'(w_pos)]) begin
                o_idx_c = IW'(w_pos);
                w_found = 1'b1;
            end
        end
        o_any_c = w_found;
    end

endmodule

// File: rtl/cordic_chan_sched.sv
// Round-robin scheduler sharing one iterative CORDIC core among NCH tone channels.
// Define CORDIC_TIMEOUT_EN to abort a stuck core after TIMEOUT_CYC wait cycles.
module cordic_chan_sched
    import cordic_sched_pkg::*;
#(
    parameter  int unsigned NCH         = 4,
    parameter  int unsigned W           = 16,
    parameter  int unsigned XINIT       = XINIT_DEF,
`ifdef CORDIC_TIMEOUT_EN
    parameter  int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
`endif
    localparam int unsigned IW          = chan_w(NCH)
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic [NCH-1:0] ch_req,
    input  logic [NCH*W-1:0] ch_angle,
    output logic [NCH-1:0] ch_grant,
    output logic           cordic_start,
    output logic [W-1:0]   cordic_angle,
    output logic [W-1:0]   cordic_x,
    output logic [W-1:0]   cordic_y,
    input  logic           cordic_done,
    input  logic [W-1:0]   cordic_cos,
    input  logic [W-1:0]   cordic_sin,
    output logic           res_valid,
    output logic [IW-1:0]  res_ch,
    output logic [W-1:0]   res_cos,
    output logic [W-1:0]   res_sin,
    output logic           res_err,
    output logic           busy
);

    state_t         r_state, w_state_nxt;
    logic [IW-1:0]  r_idx, w_idx_nxt, r_last, w_last_nxt, r_res_ch, w_res_ch_nxt;
    logic [IW-1:0]  w_pick;
    logic           w_any;
    logic [W-1:0]   w_sel_angle;
    logic [W-1:0]   r_angle, w_angle_nxt, r_x, w_x_nxt;
    logic [W-1:0]   r_cos, w_cos_nxt, r_sin, w_sin_nxt;
    logic [NCH-1:0] r_grant, w_grant_nxt;
    logic           r_start, w_start_nxt, r_valid, w_valid_nxt, r_busy, w_busy_nxt;
`ifdef CORDIC_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic           r_err, w_err_nxt;
`endif

    rr_arbiter_pick #(.NCH(NCH)) u_pick (
        .i_req   (ch_req),
        .i_last  (r_last),
        .o_idx_c (w_pick),
        .o_any_c (w_any)
    );

    // Angle of the channel the arbiter is currently pointing at.
    always_comb begin
        w_sel_angle = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_pick == IW'(i)) w_sel_angle = ch_angle[i*W +: W];
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_last_nxt   = r_last;
        w_res_ch_nxt = r_res_ch;
        w_angle_nxt  = r_angle;
        w_x_nxt      = r_x;
        w_cos_nxt    = r_cos;
        w_sin_nxt    = r_sin;
        w_grant_nxt  = '0;
        w_start_nxt  = 1'b0;
        w_valid_nxt  = 1'b0;
`ifdef CORDIC_TIMEOUT_EN
        w_cnt_inc    = r_cnt + CW'(1);
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ISSUE;
                    w_idx_nxt   = w_pick;
                    w_angle_nxt = w_sel_angle;
                    w_x_nxt     = W'(XINIT);
                    w_start_nxt = 1'b1;
                    w_grant_nxt = NCH'(1) << w_pick;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
                w_last_nxt  = r_idx;
`ifdef CORDIC_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            WAIT: begin
                // A done coinciding with the timeout limit still counts as a good result.
                if (cordic_done) begin
                    w_state_nxt  = DELIVER;
                    w_cos_nxt    = cordic_cos;
                    w_sin_nxt    = cordic_sin;
                    w_valid_nxt  = 1'b1;
                    w_res_ch_nxt = r_idx;
`ifdef CORDIC_TIMEOUT_EN
                    w_err_nxt    = 1'b0;
                end else if (w_cnt_inc == CW'(TIMEOUT_CYC)) begin
                    w_state_nxt  = DELIVER;
                    w_cos_nxt    = '0;
                    w_sin_nxt    = '0;
                    w_valid_nxt  = 1'b1;
                    w_res_ch_nxt = r_idx;
                    w_err_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt    = w_cnt_inc;
`endif
                end
            end
            DELIVER: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_last   <= IW'(NCH - 1);
            r_res_ch <= '0;
            r_angle  <= '0;
            r_x      <= '0;
            r_cos    <= '0;
            r_sin    <= '0;
            r_grant  <= '0;
            r_start  <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_last   <= w_last_nxt;
            r_res_ch <= w_res_ch_nxt;
            r_angle  <= w_angle_nxt;
            r_x      <= w_x_nxt;
            r_cos    <= w_cos_nxt;
            r_sin    <= w_sin_nxt;
            r_grant  <= w_grant_nxt;
            r_start  <= w_start_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
`ifdef CORDIC_TIMEOUT_EN
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
`endif
        end
    end

    assign ch_grant     = r_grant;
    assign cordic_start = r_start;
    assign cordic_angle = r_angle;
    assign cordic_x     = r_x;
    assign cordic_y     = '0;
    assign res_valid    = r_valid;
    assign res_ch       = r_res_ch;
    assign res_cos      = r_cos;
    assign res_sin      = r_sin;
    assign busy         = r_busy;
`ifdef CORDIC_TIMEOUT_EN
    assign res_err      = r_err;
`else
    assign res_err      = 1'b0;
`endif

endmodule
